// File: rtl/btb_resolve_ctrl.sv
// Initiator-side controller for the BTB's shared predict/resolve port: issues predict
// lookups for fetch, tracks predictions in order, and resolves them against execute outcomes.
module btb_resolve_ctrl #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int w_ptr = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fe_valid,
  input  logic [W-1:0]     fe_pc,
  output logic             fe_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [W-1:0]     pred_target,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [W-1:0]     ex_target,
  output logic             ex_ready,
  output logic             mispredict,
  output logic [W-1:0]     redirect_pc,
  output logic [w_ptr:0]   occupancy,
  output logic             btb_en,
  output logic             btb_predict,
  output logic             btb_resolve,
  output logic [W-1:0]     btb_pc,
  output logic             btb_pr_br_taken,
  output logic             btb_pr_hit,
  output logic [W-1:0]     btb_pr_target,
  input  logic             btb_hit,
  input  logic [W-1:0]     btb_target,
  input  logic             btb_out_valid
);

  typedef enum logic {IDLE, PW} state_t;

  localparam logic [w_ptr:0] FULL = (w_ptr+1)'(DEPTH);

  state_t             state, state_next;
  logic [W-1:0]       mem_pc     [DEPTH];
  logic               mem_hit    [DEPTH];
  logic [W-1:0]       mem_target [DEPTH];
  logic [w_ptr-1:0]   wr_ptr, rd_ptr;
  logic [W-1:0]       pend_pc;
  logic [W-1:0]       head_pc, head_target;
  logic               head_hit;
  logic               resolve_go, predict_go, miss, push;

  assign head_pc     = mem_pc[rd_ptr];
  assign head_hit    = mem_hit[rd_ptr];
  assign head_target = mem_target[rd_ptr];

  always_comb begin
    state_next      = state;
    resolve_go      = btb_en && ex_valid && (occupancy != '0);
    predict_go      = btb_en && (state == IDLE) && !resolve_go && fe_valid && (occupancy < FULL);
    miss            = resolve_go && ((ex_taken != head_hit) ||
                                     (ex_taken && head_hit && (ex_target != head_target)));
    // A mispredict flushes the tracker, so a response landing that cycle is dropped.
    push            = (state == PW) && btb_out_valid && !miss;
    fe_ready        = predict_go;
    ex_ready        = resolve_go;
    btb_predict     = predict_go;
    btb_resolve     = resolve_go;
    btb_pc          = '0;
    btb_pr_hit      = 1'b0;
    btb_pr_br_taken = 1'b0;
    btb_pr_target   = '0;
    if (resolve_go) begin
      btb_pc          = head_pc;
      btb_pr_hit      = head_hit;
      btb_pr_br_taken = ex_taken;
      btb_pr_target   = ex_target;
    end else if (predict_go) begin
      btb_pc = fe_pc;
    end
    case (state)
      IDLE:    if (predict_go) state_next = PW;
      PW:      if (btb_out_valid || miss) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      btb_en      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      pend_pc     <= '0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state      <= state_next;
      btb_en     <= 1'b1;
      pred_valid <= push;
      mispredict <= miss;
      if (predict_go) pend_pc <= fe_pc;
      if (push) begin
        pred_taken  <= btb_hit;
        pred_target <= btb_hit ? btb_target : pend_pc + W'(4);
      end
      if (miss) begin
        redirect_pc <= ex_taken ? ex_target : head_pc + W'(4);
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        occupancy   <= '0;
      end else begin
        if (push)       wr_ptr <= wr_ptr + w_ptr'(1);
        if (resolve_go) rd_ptr <= rd_ptr + w_ptr'(1);
        occupancy <= occupancy + {{w_ptr{1'b0}}, push} - {{w_ptr{1'b0}}, resolve_go};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]     <= pend_pc;
      mem_hit[wr_ptr]    <= btb_hit;
      mem_target[wr_ptr] <= btb_target;
    end
  end

endmodule

// File: doc/btb_resolve_ctrl.md
Name: btb_resolve_ctrl

Overview:
Initiator-side controller for the BTB's single predict/resolve port.
- Front end: accepts fetch PCs, issues BTB predict lookups, returns the prediction to fetch, and logs each prediction in an in-order tracking FIFO.
- Back end: accepts branch outcomes from execute in program order, pops the matching entry, and issues the BTB resolve/update.
- On a misprediction it raises a flush and a redirect to the front end.

Parameters:
W, 32, address/target width
DEPTH, 4, tracking FIFO entries (power of 2)
w_ptr, 2, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
fe_valid  input  1  fetch presents a PC for prediction
fe_pc  input  W  fetch PC
fe_ready  output  1  predict accepted this cycle
pred_valid  output  1  prediction result valid (1-cycle pulse)
pred_taken  output  1  predicted taken (= BTB HIT)
pred_target  output  W  next PC: TARGET if hit, else pc+4
ex_valid  input  1  execute presents a resolved branch
ex_taken  input  1  actual direction
ex_target  input  W  actual taken target
ex_ready  output  1  resolution accepted this cycle
mispredict  output  1  flush pulse
redirect_pc  output  W  correct next PC, valid with mispredict
occupancy  output  w_ptr+1  FIFO entry count
btb_en  output  1  BTB enable, 1 out of reset
btb_predict  output  1  BTB predict strobe
btb_resolve  output  1  BTB resolve strobe
btb_pc  output  W  BTB PC_addr
btb_pr_br_taken  output  1  BTB pr_br_taken
btb_pr_hit  output  1  BTB pr_hit
btb_pr_target  output  W  BTB pr_TARGET
btb_hit  input  1  BTB HIT
btb_target  input  W  BTB TARGET
btb_out_valid  input  1  BTB out_valid

Behaviour:
- Reset (rst=0, async):
  - Registered outputs 0, occupancy 0, pointers 0, state IDLE.
  - btb_en stays 0 while reset is asserted and goes to 1 on the first edge after release.
- BTB strobes are combinational. btb_predict and btb_resolve are never high in the same cycle.
- Resolve has priority over predict.
- FIFO entry: {pc, hit, target}. Pushed in the cycle btb_out_valid=1 while in state PW. Popped on an accepted resolve.
- States:
  - IDLE:
    - if ex_valid and occupancy>0: resolve issue.
    - else if fe_valid and occupancy<DEPTH: btb_predict=1, btb_pc=fe_pc, fe_ready=1, latch pc, go to PW.
  - PW (prediction wait; BTB response lands one cycle after predict):
    - When btb_out_valid=1: push entry, pred_valid=1 next cycle, go to IDLE.
    - Otherwise stay in PW, with no timeout.
    - A resolve may issue in the same cycle, provided occupancy>0.
- Resolve issue (IDLE or PW):
  - Drive the BTB: btb_resolve=1, btb_pc=head.pc, btb_pr_hit=head.hit, btb_pr_br_taken=ex_taken, btb_pr_target=ex_target.
  - Handshake: ex_ready=1, pop head.
- Mispredict condition: (ex_taken != head.hit) or (ex_taken and head.hit and ex_target != head.target).
- On mispredict:
  - Registered outputs, asserted the next cycle: mispredict=1 for one cycle; redirect_pc = ex_taken ? ex_target : head.pc+4.
  - Same edge: FIFO cleared (occupancy 0, pointers 0).
  - If in PW, the pending response is discarded: no push, no pred_valid, state to IDLE.
- Boundaries:
  - Push and pop in the same cycle: occupancy unchanged.
  - Full (occupancy=DEPTH): fe_ready=0. A resolve in that cycle does not free a slot until the next cycle.
  - Empty: ex_ready=0, and ex_valid holds.
  - In PW the pending entry is not yet in the FIFO, so it cannot be resolved early.
  - Pointers wrap modulo DEPTH.
- Arithmetic: pc+4 is truncated modulo 2^W.

Test Plan:
1. Reset, fe_valid pc=0x100, BTB returns hit=0 -> fe_ready cycle 0, pred_valid cycle 2 with pred_taken=0, pred_target=0x104, occupancy=1.
2. Entry {0x100, miss}, ex_valid taken=1 target=0x200 -> btb_resolve=1, pr_hit=0, pr_br_taken=1, pr_TARGET=0x200; next cycle mispredict=1, redirect_pc=0x200, occupancy=0.
3. Entry {0x40, hit, target 0x80}, ex taken target 0x80 -> resolve with pr_hit=1, no mispredict; same entry with ex target 0x90 -> mispredict, redirect_pc=0x90.
4. Four predicts fill the FIFO -> fe_ready=0 on the fifth; one resolve -> fifth accepted the following cycle; pointers wrap correctly after 8 push/pop pairs.
5. Predict pending (PW) while a mispredicting resolve fires -> response dropped, no pred_valid, occupancy=0, state IDLE; also fe_valid and ex_valid together in IDLE -> only btb_resolve asserted.
6. Assert rst mid-PW with occupancy=3 -> all outputs 0 immediately, occupancy=0, btb_en=0 while rst=0.
